// File: rtl/data_mem_responder.sv
// Data-side responder: word SRAM, grant wait states, exit register.
// Out-of-range accesses are flagged with the response.
module data_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned GNT_DELAY  = 0,
  parameter logic [31:0] EXIT_ADDR  = 32'h1000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o
);

  localparam int unsigned IW    = ADDR_WIDTH - 2;
  localparam int unsigned DEPTH = 2 ** IW;
  localparam logic [2:0] CNT_LOAD =
    (GNT_DELAY > 0) ? 3'(GNT_DELAY - 1) : 3'd0;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_e;

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        exit_valid_q;
  logic [31:0] exit_value_q;
  logic [31:0] mem_q [DEPTH];

  logic          grant;
  logic [29:0]   off_w;
  logic          sram_hit;
  logic          exit_hit;
  logic [IW-1:0] idx;
  logic          unused_addr;

  assign off_w       = data_addr_i[31:2] - BASE_ADDR[31:2];
  assign sram_hit    = (off_w >> IW) == 30'd0;
  assign exit_hit    = data_addr_i[31:2] == EXIT_ADDR[31:2];
  assign idx         = off_w[IW-1:0];
  assign unused_addr = ^data_addr_i[1:0];

  // Zero-delay grants bypass WAIT entirely.
  always_comb begin
    grant = 1'b0;
    if (!rst_i && data_req_i) begin
      if (GNT_DELAY == 0) begin
        grant = (state_q == ST_IDLE);
      end else begin
        grant = (state_q == ST_WAIT) && (cnt_q == 3'd0);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (GNT_DELAY != 0 && data_req_i) begin
            state_q <= ST_WAIT;
            cnt_q   <= CNT_LOAD;
          end
        end
        ST_WAIT: begin
          if (!data_req_i || cnt_q == 3'd0) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (grant && data_we_i && sram_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be_i[b]) begin
          mem_q[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q     <= 1'b0;
      rdata_q      <= 32'd0;
      err_q        <= 1'b0;
      exit_valid_q <= 1'b0;
      exit_value_q <= 32'd0;
    end else begin
      rvalid_q <= grant;
      if (grant) begin
        err_q   <= 1'b0;
        rdata_q <= 32'd0;
        unique case (1'b1)
          sram_hit: begin
            if (!data_we_i) rdata_q <= mem_q[idx];
          end
          exit_hit && !sram_hit: begin
            if (data_we_i) begin
              exit_value_q <= data_wdata_i;
              exit_valid_q <= 1'b1;
            end else begin
              rdata_q <= exit_value_q;
            end
          end
          default: begin
            err_q <= 1'b1;
            if (!data_we_i) rdata_q <= 32'hDEAD_BEEF;
          end
        endcase
      end
    end
  end

  // A response pending across a reset edge is suppressed.
  assign data_gnt_o    = grant;
  assign data_rvalid_o = rvalid_q & ~rst_i;
  assign data_rdata_o  = rdata_q;
  assign data_err_o    = err_q;
  assign exit_valid_o  = exit_valid_q;
  assign exit_value_o  = exit_value_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: table vectors with a response
// scoreboard at zero delay, hand sequences for wait states and reset.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] EXA = 32'h1000_0000;
  localparam logic [31:0] OOR = 32'h2000_0000;

  logic        rst0, req0, we0, gnt0, rv0, err0, xv0;
  logic [31:0] addr0, wd0, rd0, xval0;
  logic [3:0]  be0;
  logic        rst3, req3, we3, gnt3, rv3, err3, xv3;
  logic [31:0] addr3, wd3, rd3, xval3;
  logic [3:0]  be3;
  logic        rst4, req4, we4, gnt4, rv4, err4, xv4;
  logic [31:0] addr4, wd4, rd4, xval4;
  logic [3:0]  be4;

  data_mem_responder #(.GNT_DELAY(0)) u0 (
    .clk_i(clk), .rst_i(rst0), .data_req_i(req0),
    .data_addr_i(addr0), .data_we_i(we0), .data_be_i(be0),
    .data_wdata_i(wd0), .data_gnt_o(gnt0), .data_rvalid_o(rv0),
    .data_rdata_o(rd0), .data_err_o(err0),
    .exit_valid_o(xv0), .exit_value_o(xval0));

  data_mem_responder #(.GNT_DELAY(3)) u3 (
    .clk_i(clk), .rst_i(rst3), .data_req_i(req3),
    .data_addr_i(addr3), .data_we_i(we3), .data_be_i(be3),
    .data_wdata_i(wd3), .data_gnt_o(gnt3), .data_rvalid_o(rv3),
    .data_rdata_o(rd3), .data_err_o(err3),
    .exit_valid_o(xv3), .exit_value_o(xval3));

  data_mem_responder #(.GNT_DELAY(4)) u4 (
    .clk_i(clk), .rst_i(rst4), .data_req_i(req4),
    .data_addr_i(addr4), .data_we_i(we4), .data_be_i(be4),
    .data_wdata_i(wd4), .data_gnt_o(gnt4), .data_rvalid_o(rv4),
    .data_rdata_o(rd4), .data_err_o(err4),
    .exit_valid_o(xv4), .exit_value_o(xval4));

  int checks = 0;
  int errors = 0;
  int n_rv   = 0;

  task automatic chk32(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  task automatic chk1(input string n, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", n, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t sb[$];

  always @(negedge clk) begin
    if (rv0) begin
      n_rv++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_rvalid actual=1 required=0");
      end else begin
        rsp_t e;
        e = sb.pop_front();
        chk32("sb_rdata", rd0, e.rdata);
        chk1("sb_err", err0, e.err);
      end
    end
  end

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic        xv;
    logic [31:0] xval;
  } vec_t;

  vec_t vt[$];

  initial begin
    vt.push_back('{1'b1, 32'h0,    4'hF, 32'h1357_9BDF, 32'h0, 1'b0, 1'b0, 32'h0});
    vt.push_back('{1'b1, 32'h40,   4'hF, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b0, 32'h0});
    vt.push_back('{1'b0, 32'h40,   4'h0, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0});
    vt.push_back('{1'b1, 32'h40,   4'hF, 32'h1122_3344, 32'h0, 1'b0, 1'b0, 32'h0});
    vt.push_back('{1'b1, 32'h40,   4'h5, 32'hAABB_CCDD, 32'h0, 1'b0, 1'b0, 32'h0});
    vt.push_back('{1'b0, 32'h40,   4'hF, 32'h0, 32'h11BB_33DD, 1'b0, 1'b0, 32'h0});
    vt.push_back('{1'b1, 32'h44,   4'hF, 32'h0F0F_0F0F, 32'h0, 1'b0, 1'b0, 32'h0});
    vt.push_back('{1'b1, 32'h44,   4'h0, 32'h1234_5678, 32'h0, 1'b0, 1'b0, 32'h0});
    vt.push_back('{1'b0, 32'h44,   4'h0, 32'h0, 32'h0F0F_0F0F, 1'b0, 1'b0, 32'h0});
    vt.push_back('{1'b1, EXA,      4'hF, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0});
    vt.push_back('{1'b1, EXA,      4'h0, 32'h5, 32'h0, 1'b0, 1'b1, 32'h5});
    vt.push_back('{1'b0, EXA,      4'h0, 32'h0, 32'h5, 1'b0, 1'b1, 32'h5});
    vt.push_back('{1'b0, OOR,      4'h0, 32'h0, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h5});
    vt.push_back('{1'b1, OOR,      4'hF, 32'h7777_7777, 32'h0, 1'b1, 1'b1, 32'h5});
    vt.push_back('{1'b0, 32'h0,    4'h0, 32'h0, 32'h1357_9BDF, 1'b0, 1'b1, 32'h5});
    vt.push_back('{1'b1, 32'hFFFC, 4'hF, 32'hA5A5_A5A5, 32'h0, 1'b0, 1'b1, 32'h5});
    vt.push_back('{1'b0, 32'hFFFF, 4'h0, 32'h0, 32'hA5A5_A5A5, 1'b0, 1'b1, 32'h5});
    vt.push_back('{1'b0, 32'h1_0000, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h5});
    vt.push_back('{1'b0, EXA + 32'd3, 4'h0, 32'h0, 32'h5, 1'b0, 1'b1, 32'h5});
    vt.push_back('{1'b1, EXA + 32'd4, 4'hF, 32'h1, 32'h0, 1'b1, 1'b1, 32'h5});
    vt.push_back('{1'b0, EXA,      4'h0, 32'h0, 32'h5, 1'b0, 1'b1, 32'h5});

    rst0 = 1'b1; rst3 = 1'b1; rst4 = 1'b1;
    req0 = 1'b1; addr0 = 32'h40; we0 = 1'b0; be0 = 4'h0; wd0 = 32'h0;
    req3 = 1'b0; addr3 = 32'h0;  we3 = 1'b0; be3 = 4'h0; wd3 = 32'h0;
    req4 = 1'b0; addr4 = 32'h0;  we4 = 1'b0; be4 = 4'h0; wd4 = 32'h0;

    @(negedge clk);
    chk1("rst_gnt_blocked", gnt0, 1'b0);
    chk1("rst_rvalid", rv0, 1'b0);
    @(posedge clk); #1;
    rst0 = 1'b0; rst3 = 1'b0; rst4 = 1'b0; req0 = 1'b0;
    @(negedge clk);
    chk1("reset_gnt", gnt0, 1'b0);
    chk1("reset_rvalid", rv0, 1'b0);
    chk32("reset_rdata", rd0, 32'h0);
    chk1("reset_err", err0, 1'b0);
    chk1("reset_exit_valid", xv0, 1'b0);
    chk32("reset_exit_value", xval0, 32'h0);

    // Back-to-back vectors with req held: full throughput.
    foreach (vt[i]) begin
      @(posedge clk); #1;
      req0 = 1'b1; we0 = vt[i].we; addr0 = vt[i].addr;
      be0 = vt[i].be; wd0 = vt[i].wdata;
      @(negedge clk);
      chk1("tbl_gnt", gnt0, 1'b1);
      if (gnt0) sb.push_back('{vt[i].rdata, vt[i].err});
      if (i > 0) begin
        chk1("tbl_exit_valid", xv0, vt[i-1].xv);
        chk32("tbl_exit_value", xval0, vt[i-1].xval);
      end
    end
    @(posedge clk); #1;
    req0 = 1'b0;
    @(negedge clk);
    chk1("tbl_exit_valid_last", xv0, vt[vt.size()-1].xv);
    chk32("tbl_exit_value_last", xval0, vt[vt.size()-1].xval);
    chk1("idle_gnt", gnt0, 1'b0);

    // Grant right before reset: its response must vanish.
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0;
    @(negedge clk);
    chk1("pre_rst_gnt", gnt0, 1'b1);
    @(posedge clk); #1;
    rst0 = 1'b1; req0 = 1'b0;
    @(negedge clk);
    chk1("rst_kills_rvalid", rv0, 1'b0);
    @(posedge clk); #1;
    rst0 = 1'b0;
    @(negedge clk);
    chk1("rst_exit_valid_clr", xv0, 1'b0);
    chk32("rst_exit_value_clr", xval0, 32'h0);
    chk1("rst_rvalid_after", rv0, 1'b0);

    // GNT_DELAY=3: store then load, each paying full delay.
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        req3 = 1'b1; we3 = 1'b1; addr3 = 32'h80;
        be3 = 4'hF; wd3 = 32'hABCD_0123;
      end else if (c == 4) begin
        we3 = 1'b0; be3 = 4'h0; wd3 = 32'h0;
      end else if (c == 8) begin
        req3 = 1'b0;
      end
      @(negedge clk);
      chk1($sformatf("d3_gnt_c%0d", c), gnt3, c == 3 || c == 7);
      chk1($sformatf("d3_rvalid_c%0d", c), rv3, c == 4 || c == 8);
      if (c == 4) chk32("d3_store_rdata", rd3, 32'h0);
      if (c == 8) begin
        chk32("d3_load_rdata", rd3, 32'hABCD_0123);
        chk1("d3_load_err", err3, 1'b0);
      end
    end

    // GNT_DELAY=4: reset for one cycle while waiting.
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        req4 = 1'b1; we4 = 1'b0; addr4 = OOR;
      end else if (c == 2) begin
        rst4 = 1'b1;
      end else if (c == 3) begin
        rst4 = 1'b0;
      end else if (c == 8) begin
        req4 = 1'b0;
      end
      @(negedge clk);
      chk1($sformatf("d4_gnt_c%0d", c), gnt4, c == 7);
      chk1($sformatf("d4_rvalid_c%0d", c), rv4, c == 8);
      if (c == 3) begin
        chk32("d4_rst_rdata", rd4, 32'h0);
        chk1("d4_rst_err", err4, 1'b0);
        chk1("d4_rst_exit_valid", xv4, 1'b0);
        chk32("d4_rst_exit_value", xval4, 32'h0);
      end
      if (c == 8) begin
        chk32("d4_oor_rdata", rd4, 32'hDEAD_BEEF);
        chk1("d4_oor_err", err4, 1'b1);
      end
    end

    @(negedge clk);
    chk32("sb_drained", 32'(sb.size()), 32'd0);
    chk32("rvalid_count", 32'(n_rv), 32'(vt.size()));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
